led_matrix_frame_tx: RTL and testbench

Serial frame transmitter feeding the LED matrix driver's shift-chain input. It accepts one 64-bit frame per valid/ready handshake and serializes it on a data line with a generated data clock. It then pulses strobe so the driver latches the frame into its display buffer. It sits between the host-side frame source (pattern generator or SPI bridge) and the driver's din/dclk/strobe pins.

---
 rtl/led_matrix_frame_tx.sv | 127 ++++++++++++
 tb/tb_led_matrix_frame_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_frame_tx.sv
// Serial frame transmitter for the LED matrix driver chain: takes one frame per
// valid/ready handshake, shifts it out MSB first with a generated clock, then strobes.
module led_matrix_frame_tx #(
    parameter int NLEDS       = 64,
    parameter int HALF_PERIOD = 4,
    parameter int STROBE_LEN  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NLEDS-1:0] frame_data,
    input  logic             frame_valid,
    output logic             frame_ready,
    output logic             sdata,
    output logic             sclk,
    output logic             sstrobe,
    output logic             busy,
    output logic             done
);

    localparam int PMAX = (HALF_PERIOD > STROBE_LEN) ? HALF_PERIOD : STROBE_LEN;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int BW   = $clog2(NLEDS);

    localparam logic [PW-1:0] H_LAST   = PW'(HALF_PERIOD - 1);
    localparam logic [PW-1:0] S_LAST   = PW'(STROBE_LEN - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NLEDS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_HIGH  = 2'd2;
    localparam logic [1:0] ST_LATCH = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [NLEDS-1:0] shift_q, shift_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic             done_d;

    logic ready_q, busy_q, sclk_q, sdata_q, sstrobe_q, done_q;

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_valid && ready_q) begin
                    state_d = ST_SETUP;
                    shift_d = frame_data;
                    bit_d   = '0;
                    phase_d = '0;
                end
            end
            ST_SETUP: begin
                if (phase_q == H_LAST) begin
                    phase_d = '0;
                    state_d = ST_HIGH;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            ST_HIGH: begin
                if (phase_q == H_LAST) begin
                    phase_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_LATCH;
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        shift_d = {shift_q[NLEDS-2:0], 1'b0};
                        state_d = ST_SETUP;
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            default: begin
                if (phase_q == S_LAST) begin
                    phase_d = '0;
                    bit_d   = '0;
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
        endcase
    end

    // Pin outputs are registered from the next state so they line up with the state they describe.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_q     <= '0;
            phase_q   <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            sclk_q    <= 1'b0;
            sdata_q   <= 1'b0;
            sstrobe_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            phase_q   <= phase_d;
            ready_q   <= (state_d == ST_IDLE);
            busy_q    <= (state_d != ST_IDLE);
            sclk_q    <= (state_d == ST_HIGH);
            sdata_q   <= ((state_d == ST_SETUP) || (state_d == ST_HIGH)) ? shift_d[NLEDS-1] : 1'b0;
            sstrobe_q <= (state_d == ST_LATCH);
            done_q    <= done_d;
        end
    end

    assign frame_ready = ready_q;
    assign busy        = busy_q;
    assign sclk        = sclk_q;
    assign sdata       = sdata_q;
    assign sstrobe     = sstrobe_q;
    assign done        = done_q;

endmodule

// File: tb/tb_led_matrix_frame_tx.sv
// Self-checking bench for led_matrix_frame_tx: two instances (H=2/S=2 and H=1/S=1),
// each with a behavioural shift-chain receiver and a cycle-offset waveform model.
module tb_led_matrix_frame_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] frame_data;
    logic        valid_a, valid_b;
    logic        ready_a, sdata_a, sclk_a, sstrobe_a, busy_a, done_a;
    logic        ready_b, sdata_b, sclk_b, sstrobe_b, busy_b, done_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    led_matrix_frame_tx #(.NLEDS(64), .HALF_PERIOD(2), .STROBE_LEN(2)) dut_a (
        .clk(clk), .reset(reset), .frame_data(frame_data), .frame_valid(valid_a),
        .frame_ready(ready_a), .sdata(sdata_a), .sclk(sclk_a), .sstrobe(sstrobe_a),
        .busy(busy_a), .done(done_a)
    );

    led_matrix_frame_tx #(.NLEDS(64), .HALF_PERIOD(1), .STROBE_LEN(1)) dut_b (
        .clk(clk), .reset(reset), .frame_data(frame_data), .frame_valid(valid_b),
        .frame_ready(ready_b), .sdata(sdata_b), .sclk(sclk_b), .sstrobe(sstrobe_b),
        .busy(busy_b), .done(done_b)
    );

    // Receiver models: chain shifts toward higher indices on dclk, buffer latches on strobe.
    logic [63:0] chain_a = '0, buf_a = '0, chain_b = '0, buf_b = '0;
    int rises_a = 0, rises_b = 0, strobes_a = 0, strobes_b = 0;

    always @(posedge sclk_a) begin
        chain_a <= {chain_a[62:0], sdata_a};
        rises_a <= rises_a + 1;
    end
    always @(posedge sstrobe_a) begin
        buf_a     <= chain_a;
        strobes_a <= strobes_a + 1;
    end
    always @(posedge sclk_b) begin
        chain_b <= {chain_b[62:0], sdata_b};
        rises_b <= rises_b + 1;
    end
    always @(posedge sstrobe_b) begin
        buf_b     <= chain_b;
        strobes_b <= strobes_b + 1;
    end

    // Observation vector: {frame_ready, busy, sclk, sdata, sstrobe, done}
    logic [5:0] obs_a, obs_b;
    assign obs_a = {ready_a, busy_a, sclk_a, sdata_a, sstrobe_a, done_a};
    assign obs_b = {ready_b, busy_b, sclk_b, sdata_b, sstrobe_b, done_b};

    typedef struct {
        int         k;
        logic [5:0] exp;
    } vec_t;

    vec_t       tbl[13];
    logic [5:0] obs_log[0:600];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs k cycles after the accepting edge: 2h cycles per bit
    // (low half then high half), then s strobe cycles, then the done/ready cycle.
    function automatic logic [5:0] model(input logic [63:0] f, input int k, input int h, input int s);
        int   bits_end;
        int   b;
        int   ph;
        logic hi;
        logic d;
        bits_end = 2 * h * 64;
        if (k <= bits_end) begin
            b  = (k - 1) / (2 * h);
            ph = (k - 1) % (2 * h);
            hi = (ph >= h);
            d  = f[63 - b];
            return {1'b0, 1'b1, hi, d, 1'b0, 1'b0};
        end else if (k <= bits_end + s) begin
            return 6'b010010;
        end
        return 6'b100001;
    endfunction

    // Caller has set frame_data/valid; the first tick is the accepting edge.
    // Ends in the done cycle so the caller may chain another frame immediately.
    task automatic run_frame(input bit sel, input int h, input int s, input logic [63:0] f,
                             input bit poke, input logic [63:0] poke_data, input string tag);
        int         kmax;
        int         r0;
        int         st0;
        int         busy_cnt;
        logic [5:0] o;
        kmax     = 2 * h * 64 + s + 1;
        busy_cnt = 0;
        r0       = sel ? rises_b : rises_a;
        st0      = sel ? strobes_b : strobes_a;
        tick();
        valid_a = 1'b0;
        valid_b = 1'b0;
        for (int k = 1; k <= kmax; k++) begin
            if (k > 1) tick();
            if (poke && k == 20) begin
                frame_data = poke_data;
                if (sel) valid_b = 1'b1;
                else     valid_a = 1'b1;
            end
            o = sel ? obs_b : obs_a;
            obs_log[k] = o;
            busy_cnt += int'(o[4]);
            check($sformatf("%s k=%0d", tag, k), o, model(f, k, h, s));
        end
        check({tag, " sclk_rises"}, (sel ? rises_b : rises_a) - r0, 64);
        check({tag, " strobe_pulses"}, (sel ? strobes_b : strobes_a) - st0, 1);
        check({tag, " busy_cycles"}, busy_cnt, kmax - 1);
        check({tag, " latched"}, sel ? buf_b : buf_a, f);
    endtask

    task automatic idle_checks(input bit sel, input int n, input string tag);
        valid_a = 1'b0;
        valid_b = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            check($sformatf("%s idle%0d", tag, i), sel ? obs_b : obs_a, 6'b100000);
        end
    endtask

    task automatic random_frames(input bit sel, input int h, input int s, input int n, input string tag);
        logic [63:0] f;
        valid_a = 1'b0;
        valid_b = 1'b0;
        for (int i = 0; i < n; i++) begin
            f = {$urandom, $urandom};
            frame_data = f;
            if (sel) valid_b = 1'b1;
            else     valid_a = 1'b1;
            run_frame(sel, h, s, f, 1'b0, '0, $sformatf("%s%0d", tag, i));
            if ($urandom_range(0, 1) == 0) idle_checks(sel, $urandom_range(1, 3), $sformatf("%s%0d", tag, i));
        end
        idle_checks(sel, 1, {tag, " end"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] f;
        logic [63:0] prev_buf;
        int          st0;

        tbl[0]  = '{1,   6'b010100};
        tbl[1]  = '{2,   6'b010100};
        tbl[2]  = '{3,   6'b011100};
        tbl[3]  = '{4,   6'b011100};
        tbl[4]  = '{5,   6'b010000};
        tbl[5]  = '{7,   6'b011000};
        tbl[6]  = '{252, 6'b011000};
        tbl[7]  = '{253, 6'b010100};
        tbl[8]  = '{255, 6'b011100};
        tbl[9]  = '{256, 6'b011100};
        tbl[10] = '{257, 6'b010010};
        tbl[11] = '{258, 6'b010010};
        tbl[12] = '{259, 6'b100001};

        reset      = 1'b1;
        valid_a    = 1'b0;
        valid_b    = 1'b0;
        frame_data = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("reset a%0d", i), obs_a, 6'b100000);
            check($sformatf("reset b%0d", i), obs_b, 6'b100000);
        end
        reset = 1'b0;
        idle_checks(1'b0, 3, "post_reset a");
        idle_checks(1'b1, 3, "post_reset b");

        // Single frame with timing spot-checks from the table
        frame_data = 64'h8000_0000_0000_0001;
        valid_a    = 1'b1;
        run_frame(1'b0, 2, 2, 64'h8000_0000_0000_0001, 1'b0, '0, "single");
        for (int i = 0; i < 13; i++)
            check($sformatf("single_tbl k=%0d", tbl[i].k), obs_log[tbl[i].k], tbl[i].exp);
        idle_checks(1'b0, 2, "single");

        // Back-to-back loopback: second frame accepted in the done cycle
        frame_data = 64'hDEAD_BEEF_0123_4567;
        valid_a    = 1'b1;
        run_frame(1'b0, 2, 2, 64'hDEAD_BEEF_0123_4567, 1'b0, '0, "lb0");
        frame_data = 64'hFFFF_0000_A5A5_5A5A;
        valid_a    = 1'b1;
        run_frame(1'b0, 2, 2, 64'hFFFF_0000_A5A5_5A5A, 1'b0, '0, "lb1");
        idle_checks(1'b0, 2, "lb");

        // Valid while busy: new data held pending, accepted once IDLE is reached
        frame_data = 64'h0123_4567_89AB_CDEF;
        valid_a    = 1'b1;
        run_frame(1'b0, 2, 2, 64'h0123_4567_89AB_CDEF, 1'b1, 64'h5555_AAAA_0F0F_F0F0, "busy");
        run_frame(1'b0, 2, 2, 64'h5555_AAAA_0F0F_F0F0, 1'b0, '0, "busy_next");
        idle_checks(1'b0, 2, "busy");

        // Reset during bit 30
        f          = {$urandom, $urandom};
        frame_data = f;
        valid_a    = 1'b1;
        tick();
        valid_a = 1'b0;
        for (int k = 2; k <= 121; k++) tick();
        check("rst_mid pre", obs_a, model(f, 121, 2, 2));
        prev_buf = buf_a;
        st0      = strobes_a;
        reset    = 1'b1;
        tick();
        check("rst_mid outputs", obs_a, 6'b100000);
        reset = 1'b0;
        idle_checks(1'b0, 5, "rst_mid");
        check("rst_mid no_strobe", strobes_a - st0, 0);
        check("rst_mid buffer_kept", buf_a, prev_buf);
        f          = {$urandom, $urandom};
        frame_data = f;
        valid_a    = 1'b1;
        run_frame(1'b0, 2, 2, f, 1'b0, '0, "rst_after");
        idle_checks(1'b0, 1, "rst_after");

        random_frames(1'b0, 2, 2, 4, "rnd_a");

        // HALF_PERIOD=1, STROBE_LEN=1 instance
        frame_data = 64'h8000_0000_0000_0001;
        valid_b    = 1'b1;
        run_frame(1'b1, 1, 1, 64'h8000_0000_0000_0001, 1'b0, '0, "sweep0");
        frame_data = 64'hDEAD_BEEF_0123_4567;
        valid_b    = 1'b1;
        run_frame(1'b1, 1, 1, 64'hDEAD_BEEF_0123_4567, 1'b0, '0, "sweep1");
        idle_checks(1'b1, 2, "sweep");
        random_frames(1'b1, 1, 1, 4, "rnd_b");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
